vga_fetch_sched: RTL and testbench
==================================

Name: vga_fetch_sched

Overview:
- Schedules and arbitrates one single-port, 1-cycle-latency sprite/frame memory between two requesters.
- The display line fetcher has priority: it copies one row of pixels into the line buffer during horizontal blanking, on a pulse from the sync-timing domain logic.
- A host write port gets the memory whenever no line fetch is in progress.
- The block also owns the animation frame counter that selects which stored frame the fetcher reads.

Parameters:
- ADDR_WIDTH, 14: memory address width.
- DATA_WIDTH, 8: memory and line-buffer word width.
- LINE_WORDS, 64: words fetched per row. Must be ≥2.
- ROWS, 32: rows per animation frame. FRAME_WORDS = LINE_WORDS*ROWS.
- ROW_WIDTH, 5: width of fetch_row.
- LB_ADDR_WIDTH, 6: line-buffer address width. Must be ≥ clog2(LINE_WORDS).
- NUM_ANIM_FRAMES, 6: stored animation frames.
- FRAME_DIV, 6: display frames per animation step. Must be ≥1.
- ANIM_WIDTH, 3: width of anim_frame.

Ports:
- px_clk, in, 1: pixel clock; the only clock.
- reset_n, in, 1: asynchronous active-low reset.
- fetch_start, in, 1: one-cycle pulse requesting a fetch of row fetch_row.
- fetch_row, in, ROW_WIDTH: row index, sampled together with fetch_start.
- frame_tick, in, 1: one-cycle pulse once per display frame.
- host_valid, in, 1: host write request.
- host_ready, out, 1: host write accepted this cycle.
- host_addr, in, ADDR_WIDTH: host write address.
- host_wdata, in, DATA_WIDTH: host write data.
- mem_en, out, 1: memory access enable (registered).
- mem_we, out, 1: memory write enable (registered).
- mem_addr, out, ADDR_WIDTH: memory address (registered).
- mem_wdata, out, DATA_WIDTH: memory write data (registered).
- mem_rdata, in, DATA_WIDTH: read data, valid one cycle after a read.
- lb_we, out, 1: line-buffer write enable (registered).
- lb_addr, out, LB_ADDR_WIDTH: line-buffer word index (registered).
- lb_wdata, out, DATA_WIDTH: line-buffer write data.
- fetch_busy, out, 1: fetch in progress.
- fetch_overrun, out, 1: sticky error flag.
- anim_frame, out, ANIM_WIDTH: current animation frame index.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata, fetch_busy, fetch_overrun, anim_frame.
  - State is IDLE; internal counters are 0.
  - Reset asserted mid-fetch aborts the fetch at once. No further lb_we follows deassertion.
- State machine: IDLE → FETCH → DRAIN → IDLE.
- IDLE:
  - host_ready = (state==IDLE) && !fetch_start. This is combinational; fetch_start beats a same-cycle host_valid.
  - Host handshake (host_valid && host_ready) at edge E: during cycle E..E+1, mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata. The access is dropped after that cycle.
  - Back-to-back host writes are allowed, one per cycle.
  - fetch_start at edge E0:
    - Capture base = anim_frame*FRAME_WORDS + fetch_row*LINE_WORDS. Compute it in ≥ADDR_WIDTH+4 bits, then truncate mod 2^ADDR_WIDTH.
    - Set word counter w=0, fetch_busy=1, go to FETCH.
- FETCH:
  - In each cycle i = 0..LINE_WORDS-1 after E0: mem_en=1, mem_we=0, mem_addr = base+i (mod 2^ADDR_WIDTH).
  - After issuing word LINE_WORDS-1, go to DRAIN; mem_en falls.
- Read pipeline, applies in FETCH and DRAIN:
  - A read issued in cycle i returns mem_rdata in cycle i+1.
  - At the following edge: lb_we=1, lb_addr=i, lb_wdata=mem_rdata sampled. So line-buffer write i is visible in cycle i+2 after E0.
- DRAIN:
  - Lasts one cycle to complete the final line-buffer write.
  - fetch_busy falls at the edge where the last lb_we is driven. lb_we falls one cycle later.
  - Exactly LINE_WORDS lb_we cycles occur per fetch, contiguous, with lb_addr increasing 0..LINE_WORDS-1.
- Overrun:
  - fetch_start while state≠IDLE is ignored; the current fetch continues unaltered.
  - fetch_overrun is set and stays 1 until reset.
- Host during a fetch: host_ready=0 in FETCH and DRAIN. Host-side signals must hold per valid/ready rules; this is not checked.
- Animation counter:
  - frame_tick increments a divider 0..FRAME_DIV-1.
  - On wrap, anim_frame increments; after NUM_ANIM_FRAMES-1 it wraps to 0.
  - A fetch uses the base captured at fetch_start. A frame_tick during a fetch does not alter its addresses.
  - frame_tick and fetch_start in the same cycle: the fetch captures the pre-increment anim_frame.
- Memory outputs: mem_we=1 only for host writes. mem_en=0 in all other cycles.

Test Plan:
- Reset, then fetch_start with fetch_row=3 and anim_frame=0 → mem_addr=192..255 over 64 cycles. lb_we for 64 cycles, lb_addr=0..63, lb_wdata matches a memory model at 192+i. fetch_busy high for 65 cycles.
- 36 frame_tick pulses, then fetch row 0 → anim_frame=0 again after 6 steps (5→0 wrap). Fetch at anim_frame=2 (after 12 ticks) starts at address 4096.
- host_valid held with fetch_start asserted in the same cycle → host_ready=0 throughout the fetch. The host write completes in the first IDLE cycle with mem_we=1 and the correct address/data. There is no read/write collision in any cycle.
- Second fetch_start 10 cycles into a fetch → ignored, fetch_overrun=1, still exactly 64 lb_we. The flag stays set through a later clean fetch until reset_n=0.
- reset_n pulsed low at word 20 of a fetch → all outputs 0 immediately. No lb_we after release. A new fetch_start works normally.
- Four back-to-back host writes to addresses 0x3FFC..0x3FFF → four consecutive mem_we cycles with matching data. host_ready=1 each cycle.

Source files
------------

// File: rtl/vga_fetch_sched_if.sv
// Host write port, memory port and line-buffer write port of the fetch scheduler.
// The scheduler masters the memory and line buffer; the environment owns the host side.
interface vga_fetch_sched_if #(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 8,
  parameter int LB_ADDR_WIDTH = 6
);
  logic                     host_valid;
  logic                     host_ready;
  logic [ADDR_WIDTH-1:0]    host_addr;
  logic [DATA_WIDTH-1:0]    host_wdata;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     lb_we;
  logic [LB_ADDR_WIDTH-1:0] lb_addr;
  logic [DATA_WIDTH-1:0]    lb_wdata;

  modport master (
    input  host_valid, host_addr, host_wdata, mem_rdata,
    output host_ready, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
  );

  modport slave (
    output host_valid, host_addr, host_wdata, mem_rdata,
    input  host_ready, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
  );
endinterface

// File: rtl/vga_fetch_sched.sv
// Arbitrates a single-port sprite memory between the line fetcher (priority) and
// host writes, and keeps the animation frame counter that selects the fetched frame.
//
// state   | meaning
// S_IDLE  | memory free for host writes; fetch_start launches a row fetch
// S_FETCH | issuing LINE_WORDS sequential reads from the captured base
// S_DRAIN | last read returning; final line-buffer write is driven
module vga_fetch_sched #(
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_WIDTH      = 8,
  parameter int LINE_WORDS      = 64,
  parameter int ROWS            = 32,
  parameter int ROW_WIDTH       = 5,
  parameter int LB_ADDR_WIDTH   = 6,
  parameter int NUM_ANIM_FRAMES = 6,
  parameter int FRAME_DIV       = 6,
  parameter int ANIM_WIDTH      = 3
) (
  input  logic                  px_clk,
  input  logic                  reset_n,
  input  logic                  fetch_start,
  input  logic [ROW_WIDTH-1:0]  fetch_row,
  input  logic                  frame_tick,
  vga_fetch_sched_if.master     bus,
  output logic                  fetch_busy,
  output logic                  fetch_overrun,
  output logic [ANIM_WIDTH-1:0] anim_frame
);
  localparam int FRAME_WORDS = LINE_WORDS * ROWS;
  localparam int BASE_W      = ADDR_WIDTH + 32;
  localparam int DIV_W       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [LB_ADDR_WIDTH-1:0] w_q, w_d;
  logic                     rd_vld_q, rd_vld_d;
  logic [LB_ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                     mem_en_q, mem_en_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                     lb_we_q, lb_we_d;
  logic [LB_ADDR_WIDTH-1:0] lb_addr_q, lb_addr_d;
  logic [DATA_WIDTH-1:0]    lb_wdata_q, lb_wdata_d;
  logic                     busy_q, busy_d;
  logic                     ovr_q, ovr_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [ANIM_WIDTH-1:0]    anim_q, anim_d;
  logic [ADDR_WIDTH-1:0]    fetch_base;
  logic                     host_ready;

  // Wide intermediate so the frame/row products cannot overflow before truncation.
  assign fetch_base = ADDR_WIDTH'(BASE_W'(anim_q) * BASE_W'(FRAME_WORDS)
                                + BASE_W'(fetch_row) * BASE_W'(LINE_WORDS));

  assign host_ready = (state_q == S_IDLE) && !fetch_start;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    ovr_d       = ovr_q | (fetch_start && (state_q != S_IDLE));
    rd_vld_d    = mem_en_q && !mem_we_q;
    rd_idx_d    = w_q;
    lb_we_d     = rd_vld_q;
    lb_addr_d   = rd_vld_q ? rd_idx_q : lb_addr_q;
    lb_wdata_d  = rd_vld_q ? bus.mem_rdata : lb_wdata_q;
    div_d       = div_q;
    anim_d      = anim_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          state_d    = S_FETCH;
          w_d        = '0;
          busy_d     = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = fetch_base;
        end else if (bus.host_valid) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.host_addr;
          mem_wdata_d = bus.host_wdata;
        end
      end
      S_FETCH: begin
        if (w_q == LB_ADDR_WIDTH'(LINE_WORDS - 1)) begin
          state_d = S_DRAIN;
        end else begin
          mem_en_d   = 1'b1;
          w_d        = w_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_tick) begin
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d  = '0;
        anim_d = (anim_q == ANIM_WIDTH'(NUM_ANIM_FRAMES - 1)) ? '0 : anim_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= '0;
      lb_wdata_q  <= '0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      div_q       <= '0;
      anim_q      <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lb_we_q     <= lb_we_d;
      lb_addr_q   <= lb_addr_d;
      lb_wdata_q  <= lb_wdata_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      div_q       <= div_d;
      anim_q      <= anim_d;
    end
  end

  assign bus.host_ready = host_ready;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.lb_we      = lb_we_q;
  assign bus.lb_addr    = lb_addr_q;
  assign bus.lb_wdata   = lb_wdata_q;
  assign fetch_busy     = busy_q;
  assign fetch_overrun  = ovr_q;
  assign anim_frame     = anim_q;
endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed bench for vga_fetch_sched with a 1-cycle-latency memory model.
module tb_vga_fetch_sched;
  logic       px_clk;
  logic       reset_n;
  logic       fetch_start;
  logic [4:0] fetch_row;
  logic       frame_tick;
  logic       fetch_busy;
  logic       fetch_overrun;
  logic [2:0] anim_frame;
  logic [7:0] mem [0:16383];
  int         checks;
  int         errors;

  vga_fetch_sched_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .LB_ADDR_WIDTH(6)) bus ();

  vga_fetch_sched dut (
    .px_clk       (px_clk),
    .reset_n      (reset_n),
    .fetch_start  (fetch_start),
    .fetch_row    (fetch_row),
    .frame_tick   (frame_tick),
    .bus          (bus),
    .fetch_busy   (fetch_busy),
    .fetch_overrun(fetch_overrun),
    .anim_frame   (anim_frame)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  always @(posedge px_clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  // Launches a fetch and watches cycles 0..66 after the launching edge.
  task automatic run_fetch(input logic [4:0] row, input logic [13:0] exp_base,
                           input int inj, input bit tick_too);
    int n_en, n_lbwe, n_busy, addr_err, lbaddr_err, data_err, coll, rdy;
    logic [13:0] ea;
    n_en = 0; n_lbwe = 0; n_busy = 0; addr_err = 0;
    lbaddr_err = 0; data_err = 0; coll = 0; rdy = 0;
    fetch_row   = row;
    fetch_start = 1'b1;
    frame_tick  = tick_too;
    #1;
    if (bus.host_ready) rdy++;
    tick();
    fetch_start = 1'b0;
    frame_tick  = 1'b0;
    for (int c = 0; c <= 66; c++) begin
      if (c == inj) begin
        fetch_start = 1'b1;
        fetch_row   = row + 5'd1;
      end else if (c == inj + 1) begin
        fetch_start = 1'b0;
        fetch_row   = row;
      end
      if (c <= 65) begin
        if (bus.mem_en) begin
          n_en++;
          if (bus.mem_addr !== exp_base + 14'(c)) addr_err++;
        end
        if (bus.mem_we) coll++;
      end
      if (c <= 64 && bus.host_ready) rdy++;
      if (bus.lb_we) begin
        n_lbwe++;
        ea = exp_base + 14'(c - 2);
        if (bus.lb_addr !== 6'(c - 2)) lbaddr_err++;
        if (bus.lb_wdata !== mem[ea]) data_err++;
      end
      if (fetch_busy) n_busy++;
      if (c < 66) tick();
    end
    check("fetch_mem_en_cycles", n_en, 64);
    check("fetch_addr_errs", addr_err, 0);
    check("fetch_lb_we_cycles", n_lbwe, 64);
    check("fetch_lb_addr_errs", lbaddr_err, 0);
    check("fetch_lb_data_errs", data_err, 0);
    check("fetch_busy_cycles", n_busy, 65);
    check("fetch_rw_collision", coll, 0);
    check("fetch_host_ready", rdy, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 37 + (i >> 6));
    reset_n        = 1'b0;
    fetch_start    = 1'b0;
    fetch_row      = '0;
    frame_tick     = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.mem_rdata  = '0;
    tick();
    tick();
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_lb_we", bus.lb_we, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_overrun", fetch_overrun, 0);
    check("rst_anim", anim_frame, 0);
    reset_n = 1'b1;
    tick();
    check("idle_host_ready", bus.host_ready, 1);

    run_fetch(5'd3, 14'd192, -1, 1'b0);
    check("clean_overrun", fetch_overrun, 0);

    for (int k = 0; k < 4; k++) begin
      bus.host_valid = 1'b1;
      bus.host_addr  = 14'h3FFC + 14'(k);
      bus.host_wdata = 8'h10 + 8'(k);
      check("b2b_ready", bus.host_ready, 1);
      tick();
      check("b2b_en_we", {bus.mem_en, bus.mem_we}, 2'b11);
      check("b2b_addr", bus.mem_addr, 14'h3FFC + 14'(k));
      check("b2b_data", bus.mem_wdata, 8'h10 + 8'(k));
    end
    bus.host_valid = 1'b0;
    tick();
    check("b2b_release", bus.mem_en, 0);

    bus.host_valid = 1'b1;
    bus.host_addr  = 14'h0123;
    bus.host_wdata = 8'hA5;
    run_fetch(5'd7, 14'd448, -1, 1'b0);
    check("held_host_we", {bus.mem_en, bus.mem_we}, 2'b11);
    check("held_host_addr", bus.mem_addr, 14'h0123);
    check("held_host_data", bus.mem_wdata, 8'hA5);
    bus.host_valid = 1'b0;
    tick();
    check("held_host_once", bus.mem_en, 0);

    run_fetch(5'd1, 14'd64, 10, 1'b0);
    check("overrun_set", fetch_overrun, 1);
    run_fetch(5'd2, 14'd128, -1, 1'b0);
    check("overrun_sticky", fetch_overrun, 1);

    pulse_ticks(12);
    check("anim_after_12", anim_frame, 2);
    run_fetch(5'd0, 14'd4096, -1, 1'b0);
    pulse_ticks(18);
    check("anim_after_30", anim_frame, 5);
    pulse_ticks(6);
    check("anim_wrap_36", anim_frame, 0);
    run_fetch(5'd0, 14'd0, -1, 1'b0);

    pulse_ticks(11);
    check("anim_after_11", anim_frame, 1);
    run_fetch(5'd1, 14'd2112, -1, 1'b1);
    check("anim_same_cycle_inc", anim_frame, 2);

    fetch_row   = 5'd4;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    repeat (20) tick();
    check("mid_fetch_addr", bus.mem_addr, 14'd4096 + 14'd256 + 14'd20);
    reset_n = 1'b0;
    #1;
    check("arst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    check("arst_lb", {bus.lb_we, bus.lb_addr, bus.lb_wdata}, 0);
    check("arst_flags", {fetch_busy, fetch_overrun, anim_frame}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.lb_we || bus.mem_en || fetch_busy) stray++;
      end
      check("post_reset_quiet", stray, 0);
    end
    run_fetch(5'd4, 14'd256, -1, 1'b0);
    check("post_reset_overrun", fetch_overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
